// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared 7-segment definitions. Holds the BCD code type, the
//            segment pattern type and the pattern constants (abcdefg order,
//            bit 6 = segment a, bit 0 = segment g, active-high).
// Contents : seg_code_t, seg_pat_t, SEG_0..SEG_9, SEG_DASH, SEG_OFF
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // 4-bit digit code as it arrives from the counters (0..9 valid, 10..15 not)
  typedef logic [3:0] seg_code_t;

  // 7-bit segment pattern, abcdefg
  typedef logic [6:0] seg_pat_t;

  localparam seg_pat_t SEG_0    = 7'b1111110;
  localparam seg_pat_t SEG_1    = 7'b0110000;
  localparam seg_pat_t SEG_2    = 7'b1101101;
  localparam seg_pat_t SEG_3    = 7'b1111001;
  localparam seg_pat_t SEG_4    = 7'b0110011;
  localparam seg_pat_t SEG_5    = 7'b1011011;
  localparam seg_pat_t SEG_6    = 7'b1011111;
  localparam seg_pat_t SEG_7    = 7'b1110000;
  localparam seg_pat_t SEG_8    = 7'b1111111;
  localparam seg_pat_t SEG_9    = 7'b1111011;

  // Invalid codes show a centre dash so a corrupted digit is visible
  localparam seg_pat_t SEG_DASH = 7'b0000001;
  localparam seg_pat_t SEG_OFF  = 7'b0000000;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Purely combinational BCD to 7-segment decoder. Codes 10..15
//            decode to a dash. Reusable anywhere a single digit is decoded.
// Ports    : code_i [3:0] - BCD code in
//            seg_o  [6:0] - segment pattern out, abcdefg, active-high
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  seg_code_t code_i,
  output seg_pat_t  seg_o
);

  always_comb begin
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/display_mux.sv
`default_nettype none
// ============================================================================
// Module   : display_mux
// Purpose  : Time-multiplexed BCD to 7-segment driver. Latches N_DIGITS BCD
//            digits on a load strobe and scans them one slot at a time onto
//            a shared segment bus, with per-digit blank/blink, leading-zero
//            suppression and one dark (dead) cycle at the end of each slot.
// Params   : N_DIGITS     - digits scanned (2..8)
//            SCAN_DIV     - clock cycles per digit slot (>= 2)
//            BLINK_FRAMES - frames per blink half-period (>= 1)
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous active-high reset
//            digits_in   - BCD digits, digit i at [4i+3:4i], digit 0 rightmost
//            load        - one-cycle strobe capturing digits_in
//            blank_mask  - bit i forces digit i dark
//            blink_mask  - bit i makes digit i blink
//            lz_suppress - enables leading-zero suppression
//            seg_out     - segments abcdefg, active-high (registered)
//            digit_sel   - one-hot digit enable, 0 in dead cycle (registered)
//            frame_done  - one-cycle pulse as the scan returns to digit 0
// Revision : 1.0 - initial release
// ============================================================================
module display_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_suppress,
  output logic [6:0]            seg_out,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_done
);

  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FCNT_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FCNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                  blink_q, blink_d;
  logic                  wrap_q, wrap_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   sel_q, sel_d;
  logic                  frame_done_q, frame_done_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                div_end;
  seg_code_t           cur_code;
  seg_pat_t            cur_pat;
  logic                cur_blank;
  logic                cur_blink;
  logic                cur_lz;
  logic                cur_dark;
  logic [N_DIGITS-1:0] sel_hot;

  // upper_zero[i] = shadow digits N_DIGITS-1..i are all zero
  logic [N_DIGITS:0]   upper_zero;
  logic [N_DIGITS-1:0] lz_dark;

  assign upper_zero[N_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
    assign upper_zero[gi] = (shadow_q[4*gi +: 4] == 4'd0) && upper_zero[gi+1];
    if (gi == 0) begin : g_lz_digit0
      // The rightmost digit always shows, so an all-zero value reads "0"
      assign lz_dark[gi] = 1'b0;
    end else begin : g_lz_upper
      assign lz_dark[gi] = lz_suppress && upper_zero[gi];
    end
  end

  // --------------------------------------------------------------------------
  // Scan sequencing: divider, index, frame and blink counters
  // --------------------------------------------------------------------------
  always_comb begin
    shadow_d    = load ? digits_in : shadow_q;

    div_end     = (div_q == DIV_LAST);
    div_d       = div_end ? '0 : div_q + 1'b1;

    idx_d       = idx_q;
    if (div_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // The index wraps at the dead-cycle edge; frame_done must coincide with
    // digit 0 reappearing one edge later, so the wrap is delayed by a flop.
    wrap_d       = div_end && (idx_q == IDX_LAST);
    frame_done_d = wrap_q;

    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (wrap_q) begin
      if (frame_cnt_q == FCNT_LAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-slot selection of the active digit's code and mask bits
  // --------------------------------------------------------------------------
  always_comb begin
    cur_code  = '0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    sel_hot   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code   = shadow_q[4*i +: 4];
        cur_blank  = blank_mask[i];
        cur_blink  = blink_mask[i];
        cur_lz     = lz_dark[i];
        sel_hot[i] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .code_i (cur_code),
    .seg_o  (cur_pat)
  );

  // --------------------------------------------------------------------------
  // Output next-state
  // --------------------------------------------------------------------------
  always_comb begin
    // The phase being entered at this edge is used so that the first cycle
    // of a new blink half-period already follows the new phase.
    cur_dark = cur_blank || (cur_blink && blink_d) || cur_lz;

    seg_d = SEG_OFF;
    sel_d = '0;
    if (!div_end) begin
      sel_d = sel_hot;
      // Blanking takes precedence over everything, including the dash
      seg_d = cur_dark ? SEG_OFF : cur_pat;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      div_q        <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      blink_q      <= 1'b0;
      wrap_q       <= 1'b0;
      seg_q        <= SEG_OFF;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_q      <= blink_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign digit_sel  = sel_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_mux
// Purpose  : Self-checking bench for display_mux. A position-based reference
//            model (edges since reset -> slot/offset/frame) predicts every
//            registered output cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_mux;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * S;

  logic           clk = 1'b0;
  logic           reset;
  logic [4*N-1:0] digits_in;
  logic           load;
  logic [N-1:0]   blank_mask;
  logic [N-1:0]   blink_mask;
  logic           lz_suppress;
  logic [6:0]     seg_out;
  logic [N-1:0]   digit_sel;
  logic           frame_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int             pos;
  logic [4*N-1:0] shadow_m;
  logic [6:0]     pat [16];

  always #5 clk = ~clk;

  display_mux #(
    .N_DIGITS     (N),
    .SCAN_DIV     (S),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .load        (load),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .seg_out     (seg_out),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at pos %0d: got %0h expected %0h", tag, pos, obs, exp);
    end
  endtask

  // One clock edge: predict outputs from the model, apply load, then compare.
  task automatic tick();
    int         slot;
    int         off;
    int         frame;
    logic       phase;
    logic       allz;
    logic       dark;
    logic [3:0] code;
    logic [6:0] e_seg;
    logic [N-1:0] e_sel;
    logic       e_fd;
    @(posedge clk);
    off   = pos % S;
    slot  = (pos / S) % N;
    frame = pos / FRAME;
    phase = ((frame / BF) % 2) == 1;
    code  = shadow_m[4*slot +: 4];
    allz  = 1'b1;
    for (int j = slot; j < N; j++) begin
      if (shadow_m[4*j +: 4] != 4'd0) allz = 1'b0;
    end
    dark = blank_mask[slot] || (blink_mask[slot] && phase) ||
           (lz_suppress && slot != 0 && allz);
    e_sel = '0;
    e_seg = 7'b0;
    if (off != S - 1) begin
      e_sel[slot] = 1'b1;
      e_seg       = dark ? 7'b0 : pat[code];
    end
    e_fd = (pos > 0) && (pos % FRAME == 0);
    if (load) shadow_m = digits_in;
    pos++;
    #1;
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("digit_sel", 32'(digit_sel), 32'(e_sel));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  // Assert reset away from a clock edge; outputs must clear immediately.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_seg_out", 32'(seg_out), 32'd0);
    check("rst_digit_sel", 32'(digit_sel), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_sel", 32'(digit_sel), 32'd0);
    reset    = 1'b0;
    pos      = 0;
    shadow_m = '0;
  endtask

  task automatic load_value(input logic [4*N-1:0] v);
    digits_in = v;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  initial begin
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
    pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
    pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
    pat[9] = 7'b1111011;
    for (int k = 10; k < 16; k++) pat[k] = 7'b0000001;

    reset       = 1'b0;
    load        = 1'b0;
    digits_in   = '0;
    blank_mask  = '0;
    blink_mask  = '0;
    lz_suppress = 1'b0;
    pos         = 0;
    shadow_m    = '0;
    #2;
    do_reset();

    // Basic scan of 1234
    load_value(16'h1234);
    repeat (2 * FRAME) tick();

    // Invalid codes
    load_value(16'h00AF);
    repeat (FRAME) tick();

    // Leading-zero suppression
    lz_suppress = 1'b1;
    load_value(16'h0050);
    repeat (FRAME) tick();
    load_value(16'h0000);
    repeat (FRAME) tick();
    load_value(16'h0305);
    repeat (FRAME) tick();
    lz_suppress = 1'b0;

    // Blank mask over a dash digit
    blank_mask = 4'b0010;
    load_value(16'h98E7);
    repeat (FRAME) tick();
    blank_mask = '0;

    // Blinking from a fresh reset so frame numbers start at 0
    do_reset();
    blink_mask = 4'b0001;
    load_value(16'h1234);
    repeat (7 * FRAME) tick();
    blink_mask = '0;

    // Mid-slot reset while digit 2 is active
    while (pos % FRAME != 2 * S + 1) tick();
    do_reset();
    repeat (FRAME) tick();

    // Load during a dead cycle
    load_value(16'h4321);
    while (pos % S != S - 1) tick();
    load_value(16'h8765);
    repeat (FRAME) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int d = 0; d < N; d++) begin
          digits_in[4*d +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) begin
        blank_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0;
        blink_mask  = 4'($urandom);
        lz_suppress = 1'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        load = 1'b0;
        do_reset();
      end
      tick();
    end
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
